// File: rtl/dmem_ctrl.sv
// Round-robin arbiter and sub-word sequencer between the core (C) and debug (D)
// ports and the 64-bit word-addressed data RAM.
module dmem_ctrl #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [2:0]  c_funct3,
    input  logic [63:0] c_addr,
    input  logic [63:0] c_wdata,
    output logic        c_gnt,
    output logic        c_done,
    output logic        c_err,
    output logic [63:0] c_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_gnt,
    output logic        d_done,
    output logic        d_err,
    output logic [63:0] d_rdata,
    output logic        mem_we,
    output logic [63:0] mem_a,
    output logic [63:0] mem_wd,
    input  logic [63:0] mem_rd,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [63:0] ADDR_LIMIT = 64'(MEM_WORDS) << 3;

    state_t      r_state;
    state_t      w_stateNext;
    logic        r_rrLast;
    logic        r_owner;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_cRdata;
    logic [63:0] r_dRdata;

    logic        w_grantC;
    logic        w_grantD;
    logic        w_misaligned;
    logic        w_err;
    logic [5:0]  w_shift;
    logic [63:0] w_lane;
    logic [63:0] w_loadData;
    logic [63:0] w_sizeMask;
    logic [63:0] w_laneMask;
    logic [63:0] w_merged;
    logic [63:0] w_result;

    // r_rrLast/r_owner encode the port as 0=C, 1=D; a tie goes to the port not served last.
    assign w_grantC = c_req && (!d_req || r_rrLast);
    assign w_grantD = d_req && !w_grantC;

    always_comb begin
        w_misaligned = 1'b0;
        case (r_funct3[1:0])
            2'b01:   w_misaligned = r_addr[0];
            2'b10:   w_misaligned = |r_addr[1:0];
            2'b11:   w_misaligned = |r_addr[2:0];
            default: w_misaligned = 1'b0;
        endcase
    end

    assign w_err = (r_funct3 == 3'b111) || (r_we && r_funct3[2]) || w_misaligned
                   || (r_addr >= ADDR_LIMIT);

    assign w_shift = {r_addr[2:0], 3'b000};
    assign w_lane  = mem_rd >> w_shift;

    always_comb begin
        w_loadData = 64'd0;
        w_sizeMask = 64'hFFFF_FFFF_FFFF_FFFF;
        case (r_funct3)
            3'b000:  w_loadData = {{56{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_loadData = {{48{w_lane[15]}}, w_lane[15:0]};
            3'b010:  w_loadData = {{32{w_lane[31]}}, w_lane[31:0]};
            3'b011:  w_loadData = w_lane;
            3'b100:  w_loadData = {56'd0, w_lane[7:0]};
            3'b101:  w_loadData = {48'd0, w_lane[15:0]};
            3'b110:  w_loadData = {32'd0, w_lane[31:0]};
            default: w_loadData = 64'd0;
        endcase
        case (r_funct3[1:0])
            2'b00:   w_sizeMask = 64'h0000_0000_0000_00FF;
            2'b01:   w_sizeMask = 64'h0000_0000_0000_FFFF;
            2'b10:   w_sizeMask = 64'h0000_0000_FFFF_FFFF;
            default: w_sizeMask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    // Sub-word stores are a read-modify-write of the whole word within the single ACCESS cycle.
    assign w_laneMask = w_sizeMask << w_shift;
    assign w_merged   = (mem_rd & ~w_laneMask) | ((r_wdata << w_shift) & w_laneMask);
    assign w_result   = (r_we || w_err) ? 64'd0 : w_loadData;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Outputs decode purely from state, so an async reset drops mem_we at once.
    always_comb begin
        w_stateNext = r_state;
        c_gnt       = 1'b0;
        d_gnt       = 1'b0;
        c_done      = 1'b0;
        d_done      = 1'b0;
        c_err       = 1'b0;
        d_err       = 1'b0;
        mem_we      = 1'b0;
        mem_wd      = 64'd0;
        busy        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_grantC || w_grantD) begin
                    w_stateNext = ACCESS;
                end
            end
            ACCESS: begin
                w_stateNext = RESP;
                c_gnt       = !r_owner;
                d_gnt       = r_owner;
                mem_we      = r_we && !w_err;
                mem_wd      = (r_we && !w_err) ? w_merged : 64'd0;
            end
            RESP: begin
                w_stateNext = IDLE;
                c_done      = !r_owner;
                d_done      = r_owner;
                c_err       = !r_owner && w_err;
                d_err       = r_owner && w_err;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    assign mem_a   = {r_addr[63:3], 3'b000};
    assign c_rdata = r_cRdata;
    assign d_rdata = r_dRdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rrLast <= 1'b1;
            r_owner  <= 1'b0;
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 64'd0;
            r_wdata  <= 64'd0;
            r_cRdata <= 64'd0;
            r_dRdata <= 64'd0;
        end else begin
            if (r_state == IDLE && (w_grantC || w_grantD)) begin
                r_rrLast <= w_grantD;
                r_owner  <= w_grantD;
                r_we     <= w_grantD ? d_we     : c_we;
                r_funct3 <= w_grantD ? d_funct3 : c_funct3;
                r_addr   <= w_grantD ? d_addr   : c_addr;
                r_wdata  <= w_grantD ? d_wdata  : c_wdata;
            end
            if (r_state == ACCESS) begin
                if (r_owner) begin
                    r_dRdata <= w_result;
                end else begin
                    r_cRdata <= w_result;
                end
            end
        end
    end

endmodule
